// File: rtl/circuit_3_if.sv
// circuit_3_if: data, select and enable bundle for the registered 16:1 bit selector (sel_onehot only with CIRCUIT_3_ONEHOT_EN)
interface circuit_3_if #(
    parameter int N_IN  = 16,
    parameter int SEL_W = 4
);
    logic [N_IN-1:0]  in;
    logic [SEL_W-1:0] select;
    logic             en;
    logic             out;
`ifdef CIRCUIT_3_ONEHOT_EN
    logic [N_IN-1:0]  sel_onehot;
    modport master (output in, output select, output en, input out, input sel_onehot);
    modport slave  (input in, input select, input en, output out, output sel_onehot);
`else
    modport master (output in, output select, output en, input out);
    modport slave  (input in, input select, input en, output out);
`endif
endinterface

// File: rtl/circuit_3.sv
// circuit_3: registered 16:1 single-bit mux built as a 2:1 tree; optional registered one-hot select decode under CIRCUIT_3_ONEHOT_EN
module circuit_3 #(
    parameter int   N_IN      = 16,
    parameter int   SEL_W     = 4,
    parameter logic RESET_VAL = 1'b0
) (
    input logic        clk,
    input logic        rst,
    circuit_3_if.slave bus
);
    if (N_IN != 2 ** SEL_W) begin : g_bad_size
        $error("circuit_3: N_IN must equal 2**SEL_W");
    end

    // Heap-ordered tree: node p has children 2p+1 (even input side) and 2p+2; leaves hold in[]
    logic [2*N_IN-2:0] tree;
    logic              mux_c;

    assign tree[N_IN-1 +: N_IN] = bus.in;

    for (genvar d = 0; d < SEL_W; d++) begin : g_lvl
        for (genvar j = 0; j < 2 ** d; j++) begin : g_node
            localparam int p = 2 ** d - 1 + j;
            assign tree[p] = bus.select[SEL_W-1-d] ? tree[2*p+2] : tree[2*p+1];
        end
    end

    assign mux_c = tree[0];

    // Output flop: async reset to RESET_VAL, loads the tree result on enabled edges, holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.out <= RESET_VAL;
        else if (bus.en) bus.out <= mux_c;
    end

`ifdef CIRCUIT_3_ONEHOT_EN
    // One-hot copy of the select captured under the same enable as out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.sel_onehot <= '0;
        else if (bus.en) bus.sel_onehot <= {{(N_IN-1){1'b0}}, 1'b1} << bus.select;
    end
`endif
endmodule

// File: tb/tb_circuit_3.sv
// tb_circuit_3: directed self-checking bench for circuit_3
module tb_circuit_3;
    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    circuit_3_if #(.N_IN(16), .SEL_W(4)) bus ();

    circuit_3 #(.N_IN(16), .SEL_W(4), .RESET_VAL(1'b0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever begin
        #5;
        clk = clk_run ? ~clk : clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] oh;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.in = '0;
        bus.select = '0;
        #2;
        check("reset_idle", {15'b0, bus.out}, 16'h0000);
`ifdef CIRCUIT_3_ONEHOT_EN
        check("reset_idle_onehot", bus.sel_onehot, 16'h0000);
`endif
        clk_run = 1'b1;
        bus.en = 1'b1;
        bus.in = 16'hffff;
        step();
        check("reset_held_over_edge", {15'b0, bus.out}, 16'h0000);
        rst = 1'b0;
        bus.en = 1'b0;
        #2;
        check("release_no_change", {15'b0, bus.out}, 16'h0000);

        bus.en = 1'b1;
        bus.in = 16'b0101_0101_0101_0101;
        bus.select = 4'b0000;
        step();
        check("sel0", {15'b0, bus.out}, 16'h0001);
        bus.select = 4'b0111;
        step();
        check("sel7", {15'b0, bus.out}, 16'h0000);
`ifdef CIRCUIT_3_ONEHOT_EN
        check("onehot_sel7", bus.sel_onehot, 16'h0080);
`endif
        bus.select = 4'b1000;
        step();
        check("sel8", {15'b0, bus.out}, 16'h0001);
        bus.select = 4'b1111;
        step();
        check("sel15", {15'b0, bus.out}, 16'h0000);

        bus.in = 16'h8000;
        bus.en = 1'b0;
        step();
        check("hold0_a", {15'b0, bus.out}, 16'h0000);
        step();
        check("hold0_b", {15'b0, bus.out}, 16'h0000);
        bus.en = 1'b1;
        step();
        check("en_resume", {15'b0, bus.out}, 16'h0001);
        bus.en = 1'b0;
        bus.in = 16'h0000;
        bus.select = 4'b0011;
        step();
        check("hold1", {15'b0, bus.out}, 16'h0001);
        bus.en = 1'b1;

        for (int s = 0; s < 16; s++) begin
            oh = 16'h0001 << s;
            bus.select = 4'(s);
            bus.in = oh;
            step();
            check($sformatf("sweep_onehot_%0d", s), {15'b0, bus.out}, 16'h0001);
`ifdef CIRCUIT_3_ONEHOT_EN
            check($sformatf("sweep_dec_%0d", s), bus.sel_onehot, oh);
`endif
            if (s == 9) begin
                #2;
                rst = 1'b1;
                #1;
                check("mid_reset", {15'b0, bus.out}, 16'h0000);
`ifdef CIRCUIT_3_ONEHOT_EN
                check("mid_reset_onehot", bus.sel_onehot, 16'h0000);
`endif
                #1;
                rst = 1'b0;
                #1;
                check("mid_release", {15'b0, bus.out}, 16'h0000);
                step();
                check("post_reset_resume", {15'b0, bus.out}, 16'h0001);
            end
            bus.in = ~oh;
            step();
            check($sformatf("sweep_inv_%0d", s), {15'b0, bus.out}, 16'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
